fp_addsub_unit: RTL and testbench
=================================

// Module: fp_addsub_unit
// PURPOSE
//  Parametrised, multi-cycle IEEE-754-style FP add/subtract unit. Successor to the fixed adder.
//  Adds a runtime add/sub select, a busy output and a fixed, deterministic latency.
//  Optional round-to-nearest-even. Sits in the FP ALU datapath and is started by a load strobe.
// PARAMETERS
//  Mantissa_Size  23  stored fraction bits (hidden bit implicit)
//  Exponent_Size  8   biased exponent bits; bias = 2^(Exponent_Size-1)-1
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  enable     in   1      1 = FSM advances; 0 = all state and outputs hold
//  load       in   1      start strobe, sampled only in IDLE/DONE with enable=1
//  op         in   1      0 = A+B, 1 = A-B (B sign inverted at capture)
//  A, B       in   N+1    operands {sign, exp, frac}; N = Mantissa_Size+Exponent_Size
//  result     out  N+1    registered result
//  done       out  1      result and flags valid
//  busy       out  1      operation in flight (ALIGN..ROUND)
//  zero_flag, overflow, underflow, NAN  out 1 each  status, registered with result
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; result=0; done/busy and all flags = 0. Reset mid-op aborts, no output.
//  FSM: IDLE -> ALIGN -> ADD -> NORM -> ROUND -> DONE. load in IDLE or DONE -> capture A,B,op, go ALIGN.
//  Latency: load sampled at edge k -> done=1 after edge k+4; busy=1 from edge k to edge k+4.
//  done holds in DONE until next accepted load; it drops on that load edge.
//  load during busy is ignored; operands are captured only on the accepted load edge.
//  enable=0 freezes every register (including done) for any number of cycles.
//  ALIGN: swap so |X|>=|Y|; shift Y right by exponent difference in one cycle; diff > Mantissa_Size+2 -> Y collapses to sticky.
//  ADD: effective add/sub on Mantissa_Size+4-bit extended mantissas (hidden, guard, round, sticky).
//  NORM: carry-out -> shift right 1, exp+1; else left shift by leading-zero count in one cycle.
//  ROUND/pack: exponent computed one bit wider than Exponent_Size to detect over/underflow.
//  Inputs with exp=0 are treated as signed zero (denormals flushed).
//  Exact cancellation -> +0, zero_flag=1.
//  Result exp >= all-ones -> {sign, all-ones, 0}, overflow=1.
//  Result exp < 1 (non-zero) -> +0, underflow=1, zero_flag=1.
//  Specials are detected in ALIGN, carried through with the same latency, and the arithmetic is bypassed:
//   - any NaN operand, or inf + (-inf) effective -> canonical quiet NaN {0, all-ones, 1, 0...0}, NAN=1.
//   - inf op finite -> that inf; overflow stays 0.
//  Flags are mutually consistent: NAN=1 forces all other flags to 0.
// CONFIGURATION
//  ROUND_NEAREST_EN defined: guard/round/sticky round-to-nearest-even in ROUND.
//   - rounding carry re-normalises (exp+1) and can raise overflow.
//  Not defined: truncate toward zero; G/R/S are dropped; ROUND is a pass-through stage.
//  Latency is identical in both builds.
// STRUCTURE
//  Shared package fp_pkg: state enum, bias/width localparams derived from Mantissa_Size/Exponent_Size,
//   quiet-NaN and infinity constant functions.
//  Sub-module fp_lzc: combinational leading-zero counter, width parameter, used in NORM.
// TESTING (32-bit, Mantissa_Size=23, Exponent_Size=8; check result exactly 4 edges after the load edge)
//  A=0x40000000 B=0x40000000 op=0 -> 0x40800000; all flags 0; busy 1 for 4 edges.
//  A=0x3F800000 B=0x3F800000 op=1 -> 0x00000000, zero_flag=1. Repeat with enable toggling -> same result, delayed.
//  A=0x7F7FFFFF B=0x7F7FFFFF op=0 -> 0x7F800000, overflow=1.
//  A=0x0080000F B=0x80800007 op=0 -> 0x00000000, underflow=1, zero_flag=1.
//  A=0x7FC00000 B=0x3F800000 -> 0x7FC00000, NAN=1.
//  A=0x7F800000 B=0x7F800000 op=1 -> 0x7FC00000, NAN=1.
//  A=0x3F800000 B=0x33800000 -> 0x3F800000 (tie to even).
//  A=0x3F800000 B=0x33800001 -> 0x3F800001 with ROUND_NEAREST_EN; 0x3F800000 without.
//  Reset asserted mid-op -> outputs 0 immediately.
//  load during busy -> ignored; the first result is unaffected.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point add/subtract unit.
//   fp_state_t  : control FSM state encoding
//   DEF_*       : default field widths (IEEE-754 single precision)
//   GRS_BITS    : guard/round/sticky bits carried below the fraction
//   fp_bias()   : exponent bias for a given exponent width
//   fp_inf()    : infinity pattern {sign, all-ones, 0}, zero-extended to 64 bits
//   fp_qnan()   : canonical quiet NaN {0, all-ones, 1, 0...0}, zero-extended to 64 bits
// Constant functions return 64-bit vectors; callers slice them to N+1 bits.
package fp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_ADD,
        ST_NORM,
        ST_ROUND,
        ST_DONE
    } fp_state_t;

    localparam int unsigned DEF_MANT_SIZE = 23;
    localparam int unsigned DEF_EXP_SIZE  = 8;
    localparam int unsigned GRS_BITS      = 3;

    function automatic int unsigned fp_bias(input int unsigned exp_size);
        return (32'd1 << (exp_size - 1)) - 32'd1;
    endfunction

    function automatic logic [63:0] fp_inf(input int unsigned man_size,
                                           input int unsigned exp_size,
                                           input logic        sign);
        logic [63:0] v;
        v = '0;
        for (int unsigned i = 0; i < exp_size; i++) begin
            v[man_size + i] = 1'b1;
        end
        v[man_size + exp_size] = sign;
        return v;
    endfunction

    function automatic logic [63:0] fp_qnan(input int unsigned man_size,
                                            input int unsigned exp_size);
        logic [63:0] v;
        v = fp_inf(man_size, exp_size, 1'b0);
        v[man_size - 1] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/fp_addsub_unit_lzc.sv
// Combinational leading-zero counter.
//   value : input vector, MSB first
//   count : number of leading zeros (WIDTH when value is all zero)
module fp_lzc #(
    parameter int unsigned WIDTH = 27,
    localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] value,
    output logic [CNT_W-1:0] count
);

    // Scanning LSB to MSB lets the highest set bit win the last assignment.
    always_comb begin
        count = CNT_W'(WIDTH);
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (value[i]) begin
                count = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_addsub_unit.sv
// Multi-cycle floating-point add/subtract unit, fixed latency of four enabled
// edges from the accepted load edge to done. Denormal inputs flush to zero.
// Build option: define ROUND_NEAREST_EN for round-to-nearest-even; otherwise
// the result is truncated toward zero.
// Ports:
//   clk, rst_n    : clock (rising edge), asynchronous active-low reset
//   enable        : 0 freezes all state and outputs
//   load          : start strobe, accepted only in IDLE/DONE
//   op            : 0 = A+B, 1 = A-B
//   A, B          : operands {sign, exp, frac}
//   result        : registered result
//   done, busy    : result valid / operation in flight
//   zero_flag, overflow, underflow, NAN : status registered with result
module fp_addsub_unit
    import fp_pkg::*;
#(
    parameter int unsigned Mantissa_Size = DEF_MANT_SIZE,
    parameter int unsigned Exponent_Size = DEF_EXP_SIZE
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 enable,
    input  logic                                 load,
    input  logic                                 op,
    input  logic [Mantissa_Size+Exponent_Size:0] A,
    input  logic [Mantissa_Size+Exponent_Size:0] B,
    output logic [Mantissa_Size+Exponent_Size:0] result,
    output logic                                 done,
    output logic                                 busy,
    output logic                                 zero_flag,
    output logic                                 overflow,
    output logic                                 underflow,
    output logic                                 NAN
);

    localparam int unsigned M   = Mantissa_Size;
    localparam int unsigned E   = Exponent_Size;
    localparam int unsigned N   = M + E;
    localparam int unsigned W   = M + 1 + GRS_BITS;   // hidden + frac + G/R/S
    localparam int unsigned EW  = E + 2;              // signed, one spare bit
    localparam int unsigned LZW = $clog2(W + 1);

    localparam logic [63:0]          QNAN_FULL = fp_qnan(M, E);
    localparam logic [N:0]           QNAN      = QNAN_FULL[N:0];
    localparam logic [E-1:0]         EXP_ONES  = '1;
    localparam logic signed [EW-1:0] EXP_MAX   = EW'((1 << E) - 1);
    localparam logic signed [EW-1:0] EXP_MIN   = EW'(1);

`ifdef ROUND_NEAREST_EN
    localparam logic RNE = 1'b1;
`else
    localparam logic RNE = 1'b0;
`endif

    fp_state_t state;

    // Captured operands (B sign already reflects op)
    logic [N:0] a_q, b_q;

    // Single operation in flight, so each stage owns its own registers
    logic              sign_q, eff_sub_q, nan_q, inf_q, zero_q;
    logic [E-1:0]      ex_q;
    logic [W-1:0]      mx_q, my_q, m_q;
    logic [W:0]        sum_q;
    logic signed [EW-1:0] e_q;

    // ALIGN stage
    logic              a_sign, b_sign, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [E-1:0]      a_exp, b_exp, x_exp, y_exp, diff;
    logic [M-1:0]      a_frac, b_frac, x_frac, y_frac;
    logic [N-1:0]      a_mag, b_mag;
    logic              x_sign, y_sign, x_zero, y_zero;
    logic [W-1:0]      mx_n, my_raw, my_n;
    logic [2*W-1:0]    sh_full;
    logic              nan_n, inf_n, sign_n;

    always_comb begin
        a_sign = a_q[N];   a_exp = a_q[N-1:M];   a_frac = a_q[M-1:0];
        b_sign = b_q[N];   b_exp = b_q[N-1:M];   b_frac = b_q[M-1:0];
        a_nan  = (a_exp == EXP_ONES) && (a_frac != '0);
        b_nan  = (b_exp == EXP_ONES) && (b_frac != '0);
        a_inf  = (a_exp == EXP_ONES) && (a_frac == '0);
        b_inf  = (b_exp == EXP_ONES) && (b_frac == '0);
        a_zero = (a_exp == '0);
        b_zero = (b_exp == '0);
        a_mag  = a_zero ? '0 : a_q[N-1:0];
        b_mag  = b_zero ? '0 : b_q[N-1:0];

        if (b_mag > a_mag) begin
            x_sign = b_sign; x_exp = b_exp; x_frac = b_frac; x_zero = b_zero;
            y_sign = a_sign; y_exp = a_exp; y_frac = a_frac; y_zero = a_zero;
        end else begin
            x_sign = a_sign; x_exp = a_exp; x_frac = a_frac; x_zero = a_zero;
            y_sign = b_sign; y_exp = b_exp; y_frac = b_frac; y_zero = b_zero;
        end

        mx_n   = x_zero ? '0 : {1'b1, x_frac, {GRS_BITS{1'b0}}};
        my_raw = y_zero ? '0 : {1'b1, y_frac, {GRS_BITS{1'b0}}};
        diff   = x_exp - y_exp;

        // Low half of the double-width shift holds everything shifted out
        sh_full = {my_raw, {W{1'b0}}} >> diff;
        if (32'(diff) > M + 2) begin
            my_n = W'(|my_raw);
        end else begin
            my_n = sh_full[2*W-1:W] | W'(|sh_full[W-1:0]);
        end

        nan_n  = a_nan | b_nan | (a_inf & b_inf & (a_sign != b_sign));
        inf_n  = a_inf | b_inf;
        sign_n = inf_n ? (a_inf ? a_sign : b_sign) : x_sign;
    end

    // ADD stage: |X| >= |Y| guarantees a non-negative difference
    logic [W:0] sum_n;

    always_comb begin
        if (eff_sub_q) begin
            sum_n = {1'b0, mx_q} - {1'b0, my_q};
        end else begin
            sum_n = {1'b0, mx_q} + {1'b0, my_q};
        end
    end

    // NORM stage
    logic [LZW-1:0]       lz;
    logic [W-1:0]         m_n;
    logic signed [EW-1:0] e_n;

    fp_lzc #(.WIDTH(W)) u_lzc (
        .value (sum_q[W-1:0]),
        .count (lz)
    );

    always_comb begin
        if (sum_q[W]) begin
            m_n = sum_q[W:1] | W'(sum_q[0]);
            e_n = {2'b00, ex_q} + EW'(1);
        end else begin
            m_n = sum_q[W-1:0] << lz;
            e_n = {2'b00, ex_q} - EW'(lz);
        end
    end

    // ROUND stage and packing
    logic                 inc;
    logic [M+1:0]         rounded;
    logic [M-1:0]         frac_out;
    logic signed [EW-1:0] e_r;
    logic [N:0]           res_n;
    logic                 zf_n, of_n, uf_n, nanf_n;

    always_comb begin
        inc      = RNE & m_q[2] & (m_q[1] | m_q[0] | m_q[3]);
        rounded  = {1'b0, m_q[W-1:GRS_BITS]} + (M+2)'(inc);
        if (rounded[M+1]) begin
            frac_out = rounded[M:1];
            e_r      = e_q + EW'(1);
        end else begin
            frac_out = rounded[M-1:0];
            e_r      = e_q;
        end

        res_n  = '0;
        zf_n   = 1'b0;
        of_n   = 1'b0;
        uf_n   = 1'b0;
        nanf_n = 1'b0;
        if (nan_q) begin
            res_n  = QNAN;
            nanf_n = 1'b1;
        end else if (inf_q) begin
            res_n = {sign_q, EXP_ONES, {M{1'b0}}};
        end else if (zero_q) begin
            zf_n = 1'b1;
        end else if (e_r >= EXP_MAX) begin
            res_n = {sign_q, EXP_ONES, {M{1'b0}}};
            of_n  = 1'b1;
        end else if (e_r < EXP_MIN) begin
            uf_n = 1'b1;
            zf_n = 1'b1;
        end else begin
            res_n = {sign_q, e_r[E-1:0], frac_out};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sign_q    <= 1'b0;
            eff_sub_q <= 1'b0;
            nan_q     <= 1'b0;
            inf_q     <= 1'b0;
            zero_q    <= 1'b0;
            ex_q      <= '0;
            mx_q      <= '0;
            my_q      <= '0;
            sum_q     <= '0;
            m_q       <= '0;
            e_q       <= '0;
            result    <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            zero_flag <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            NAN       <= 1'b0;
        end else if (enable) begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (load) begin
                        a_q   <= A;
                        b_q   <= {B[N] ^ op, B[N-1:0]};
                        done  <= 1'b0;
                        busy  <= 1'b1;
                        state <= ST_ALIGN;
                    end
                end
                ST_ALIGN: begin
                    sign_q    <= sign_n;
                    eff_sub_q <= x_sign ^ y_sign;
                    nan_q     <= nan_n;
                    inf_q     <= inf_n;
                    ex_q      <= x_exp;
                    mx_q      <= mx_n;
                    my_q      <= my_n;
                    state     <= ST_ADD;
                end
                ST_ADD: begin
                    sum_q <= sum_n;
                    state <= ST_NORM;
                end
                ST_NORM: begin
                    m_q    <= m_n;
                    e_q    <= e_n;
                    zero_q <= (sum_q == '0);
                    state  <= ST_ROUND;
                end
                ST_ROUND: begin
                    result    <= res_n;
                    zero_flag <= zf_n;
                    overflow  <= of_n;
                    underflow <= uf_n;
                    NAN       <= nanf_n;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_addsub_unit.sv
// Scoreboard bench for fp_addsub_unit (32-bit). The driver pushes expected
// results on each accepted load; the monitor pops on every rising done and
// checks result, flags and latency in edges from the load edge.
module tb_fp_addsub_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic        op = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [31:0] result;
    logic        done, busy, zero_flag, overflow, underflow, NAN;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;     // {zero_flag, overflow, underflow, NAN}
        int unsigned issue;
        int unsigned lat;
        string       name;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    logic        done_prev = 1'b0;
    logic [8:0]  pat;
    logic [31:0] held;

`ifdef ROUND_NEAREST_EN
    localparam logic [31:0] STICKY_RES = 32'h3F800001;
`else
    localparam logic [31:0] STICKY_RES = 32'h3F800000;
`endif

    fp_addsub_unit #(.Mantissa_Size(23), .Exponent_Size(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .load      (load),
        .op        (op),
        .A         (A),
        .B         (B),
        .result    (result),
        .done      (done),
        .busy      (busy),
        .zero_flag (zero_flag),
        .overflow  (overflow),
        .underflow (underflow),
        .NAN       (NAN)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (rst_n && done && !done_prev) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got result 0x%08h, expected no output", result);
            end else begin
                mon_e = q.pop_front();
                chk({mon_e.name, "_result"}, result, mon_e.res);
                chk({mon_e.name, "_flags"}, 32'({zero_flag, overflow, underflow, NAN}), 32'(mon_e.flg));
                chk({mon_e.name, "_latency"}, cyc - mon_e.issue, mon_e.lat);
            end
        end
        done_prev = done;
    end

    task automatic push_exp(input logic [31:0] res, input logic [3:0] flg,
                            input int unsigned lat, input string name);
        exp_t e;
        e.res   = res;
        e.flg   = flg;
        e.issue = cyc + 1;
        e.lat   = lat;
        e.name  = name;
        q.push_back(e);
    endtask

    task automatic wait_done(input string name);
        int unsigned n = 0;
        while (!done && n < 30) begin
            chk({name, "_busy"}, 32'(busy), 32'd1);
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got done=0, expected done=1 within 30 cycles", name);
        end else begin
            chk({name, "_busy_end"}, 32'(busy), 32'd0);
        end
    endtask

    // Called at a negedge; returns at the negedge where done is seen
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic o,
                          input logic [31:0] res, input logic [3:0] flg, input string name);
        A = a; B = b; op = o; load = 1'b1;
        push_exp(res, flg, 4, name);
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        wait_done(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000 time units");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_result", result, 32'h0);
        chk("rst_status", 32'({done, busy, zero_flag, overflow, underflow, NAN}), 32'h0);
        rst_n  = 1'b1;
        enable = 1'b1;
        @(negedge clk);

        run_op(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 4'b0000, "add_2_2");
        run_op(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b1000, "sub_cancel");

        // Same cancellation with enable toggling: 4 enabled edges land at k+9
        A = 32'h3F800000; B = 32'h3F800000; op = 1'b1; load = 1'b1;
        push_exp(32'h00000000, 4'b1000, 9, "sub_cancel_stall");
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        pat  = 9'b111001000;
        for (int i = 0; i < 9; i++) begin
            enable = pat[i];
            @(posedge clk);
            @(negedge clk);
            chk("stall_done", 32'(done), (i == 8) ? 32'd1 : 32'd0);
        end
        enable = 1'b1;

        run_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0100, "overflow");
        run_op(32'h0080000F, 32'h80800007, 1'b0, 32'h00000000, 4'b1010, "underflow");
        run_op(32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0001, "nan_in");
        run_op(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b0001, "inf_minus_inf");
        run_op(32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000, "inf_plus_one");
        run_op(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000, "sub_3_1");
        run_op(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0000, "tie_even");
        run_op(32'h3F800000, 32'h33800001, 1'b0, STICKY_RES, 4'b0000, "sticky");

        // enable=0 in DONE: load is not taken and done/result hold
        held   = result;
        enable = 1'b0;
        A = 32'h40000000; B = 32'h40000000; op = 1'b0; load = 1'b1;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            chk("freeze_done", 32'(done), 32'd1);
            chk("freeze_result", result, held);
        end
        load   = 1'b0;
        enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("freeze_release_done", 32'(done), 32'd1);

        // load held high while busy must not disturb 3.0 + 1.0
        A = 32'h40400000; B = 32'h3F800000; op = 1'b0; load = 1'b1;
        push_exp(32'h40800000, 4'b0000, 4, "load_busy");
        @(posedge clk);
        @(negedge clk);
        A = 32'h3F800000; B = 32'h3F800000;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        load = 1'b0;
        wait_done("load_busy");

        // Reset in the middle of an operation
        A = 32'h40000000; B = 32'h40000000; op = 1'b0; load = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_result", result, 32'h0);
        chk("midrst_status", 32'({done, busy, zero_flag, overflow, underflow, NAN}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("midrst_no_output", 32'(done), 32'd0);

        run_op(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000, "after_reset");

        repeat (4) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
